shift_add_multiplier: RTL

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

---
 rtl/shift_add_multiplier.sv | 133 +++++++++++++
 1 files changed

// File: rtl/shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier
//
// Sequential unsigned multiplier using the classic shift-and-add algorithm.
// One partial-product step is performed per clock, so a multiplication takes
// WIDTH CALC cycles plus one DONE cycle. The next start is accepted in the
// IDLE cycle that follows DONE.
//
// Ports
//   clk   : single clock, all state updates on the rising edge
//   rst   : synchronous active-high reset, overrides everything
//   start : request to begin a multiplication (sampled only in IDLE)
//   X     : multiplicand, unsigned, WIDTH bits
//   Y     : multiplier, unsigned, WIDTH bits
//   P     : registered product X*Y, 2*WIDTH bits, held until next result
//   busy  : high while the iteration loop is running (state CALC)
//   done  : one-cycle pulse marking P valid (state DONE)
// ---------------------------------------------------------------------------
module shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   X,
    input  logic [WIDTH-1:0]   Y,
    output logic [2*WIDTH-1:0] P,
    output logic               busy,
    output logic               done
);

    // Counter holds 0..WIDTH, so it needs ceil(log2(WIDTH+1)) bits.
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // a carries one extra bit for the carry out of the add.
    logic [WIDTH:0]     a;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   m;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     a_shift;
    logic [WIDTH-1:0]   q_shift;
    logic               last_iter;

    // Counter increment that parks at WIDTH instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    // One shift-add step: conditional add, then shift {C,A,Q} right by one.
    always_comb begin
        sum       = q[0] ? (a + {1'b0, m}) : a;
        a_shift   = {1'b0, sum[WIDTH:1]};
        q_shift   = {sum[0], q[WIDTH-1:1]};
        last_iter = (cnt == LAST_ITER);
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state == CALC);
        done = (state == DONE);
    end

    // Datapath registers. Operands are captured only on the start edge, so
    // later changes on X/Y and extra start pulses cannot disturb a result.
    always_ff @(posedge clk) begin
        if (rst) begin
            a   <= '0;
            q   <= '0;
            m   <= '0;
            cnt <= '0;
            P   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m   <= Y;
                        q   <= X;
                        a   <= '0;
                        cnt <= '0;
                    end
                end
                CALC: begin
                    a   <= a_shift;
                    q   <= q_shift;
                    cnt <= sat_inc(cnt);
                    // Result is taken from the post-shift values of the final step.
                    if (last_iter) begin
                        P <= {a_shift[WIDTH-1:0], q_shift};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
